dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the CPU data-memory request interface (data_read / data_write / address / write data in; read data / data_good out).
- Backs the interface with a word-addressed on-chip array.
- Inserts a parameterised number of wait states before each access.
- Used as the data memory in small-integration benches and in the minimal SoC, in place of the external bus.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the array. Must be a power of 2, ≥4.
- WAIT_STATES, 2: idle cycles between request acceptance and the data_good response. Range 0..15.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be aligned to DEPTH_WORDS*4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- nRst  in  1  asynchronous, active-low reset.
- data_read  in  1  read request from the CPU; level, held until data_good.
- data_write  in  1  write request from the CPU; level, held until data_good.
- data_adr_i  in  32  byte address of the request.
- data_bus_i  in  32  write data from the CPU.
- data_sel_i  in  4  byte-lane enables for writes; bit k enables byte k. Ignored on reads.
- data_bus_o  out  32  read data to the CPU.
- data_good  out  1  one-cycle pulse: the access has completed.
- busy  out  1  high in every state except IDLE.
- addr_err  out  1  one-cycle pulse, coincident with data_good, for an out-of-range address.

Behaviour:
- Reset (async assert on nRst low, sync release):
  - state=IDLE; data_bus_o=0; data_good=0; busy=0; addr_err=0; wait counter=0.
  - The entire array clears to 0.
  - Reset mid-transaction aborts it: no data_good, and any pending write is dropped.
- Address decode:
  - word index = (data_adr_i - BASE_ADDR) >> 2.
  - Address bits [1:0] are ignored; no misalignment trap.
  - In range means BASE_ADDR ≤ data_adr_i < BASE_ADDR + DEPTH_WORDS*4.
- FSM states: IDLE, WAIT, ACCESS.
  - IDLE:
    - If data_write=1: latch op=write, word index, data_bus_i, data_sel_i and the range flag; go to WAIT (or to ACCESS if WAIT_STATES=0).
    - Else if data_read=1: latch op=read, index and range flag; same transition.
    - If data_read and data_write are both high, the write wins and the read is dropped.
  - WAIT:
    - The counter loads WAIT_STATES-1 on entry and decrements each cycle.
    - Go to ACCESS when the counter is 0.
    - Requests and inputs are not resampled; inputs may change freely.
  - ACCESS (exactly one cycle):
    - Write: update the enabled byte lanes of the latched word.
    - Read: load data_bus_o from the latched word.
    - Out of range: the write is dropped, the read returns 0, and addr_err is registered high.
    - data_good is registered high. Next state is IDLE.
- Outputs and latency:
  - data_good and addr_err are registered, high for the single cycle following the ACCESS edge.
  - Latency: request sampled at IDLE edge E0 → data_good high in the cycle after edge E0+WAIT_STATES+1.
  - data_bus_o holds its last read value until the next read completes. Writes do not change it.
- Handshake:
  - The initiator deasserts its request in the cycle data_good is high.
  - A request still high on the IDLE edge after data_good is accepted as a new transaction (back-to-back), with no extra bubble.
- Read-after-write to the same word returns the merged written value on the next transaction.
- Array: synchronous write only, no read-during-write hazard, since ACCESS is a single state.

Test Plan:
- Reset: hold nRst low 2 cycles, release → data_good=0, busy=0, data_bus_o=0; read adr 0x10 → data_bus_o=0, data_good at E0+3 (WAIT_STATES=2).
- Word write/read: write 0xDEADBEEF, sel=4'b1111 to adr 0x8, then read 0x8 → data_bus_o=0xDEADBEEF; each data_good exactly 3 cycles after acceptance and 1 cycle wide.
- Byte lanes: write 0x11223344 sel=1111 to 0x20, then 0xAABBCCDD sel=0101 to 0x22 (low bits ignored), then read 0x20 → 0x11BB33DD.
- Out of range: write 0x5 to adr 0x400 (DEPTH_WORDS=256), then read 0x400 → addr_err pulses with each data_good; read returns 0; word 0 is still unchanged.
- Collision and back-to-back: data_read=data_write=1, adr 0x4, data 0x7 → write performed; hold data_read high after data_good → second transaction reads 0x7; busy low for only the one IDLE cycle between them.
- Reset mid-op: start write 0x99 to 0xC, pull nRst low during WAIT → no data_good; after release, read 0xC → 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Wait-stated data-memory responder backed by a word-addressed register array.
// A request is latched in IDLE, held through WAIT_STATES idle cycles, then completed in a single ACCESS cycle.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_adr_i,
  input  logic [31:0] data_bus_i,
  input  logic [3:0]  data_sel_i,
  output logic [31:0] data_bus_o,
  output logic        data_good,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned IW      = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        ok_q, ok_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dout_q, dout_d;
  logic        good_q, good_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic [31:0] mem_q [DEPTH_WORDS];

  // Addresses below BASE_ADDR wrap to a huge offset, so one unsigned compare covers both bounds.
  logic [31:0]   off;
  logic          in_range;
  logic [IW-1:0] idx;
  assign off      = data_adr_i - BASE_ADDR;
  assign in_range = ({1'b0, off} < SPAN);
  assign idx      = off[IW+1:2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ok_d    = ok_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    good_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_write || data_read) begin
          we_d    = data_write;
          idx_d   = idx;
          ok_d    = in_range;
          cnt_d   = WS_LOAD;
          state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
          if (data_write) begin
            wdata_d = data_bus_i;
            sel_d   = data_sel_i;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        good_d  = 1'b1;
        err_d   = !ok_q;
        state_d = S_IDLE;
        if (we_q) mem_we = ok_q;
        else      dout_d = ok_q ? mem_q[idx_q] : '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ok_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      dout_q  <= '0;
      good_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ok_q    <= ok_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
      good_q  <= good_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++)
        if (sel_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  assign data_bus_o = dout_q;
  assign data_good  = good_q;
  assign addr_err   = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WS    = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  // Posedges counted from the accepting edge up to the one after which data_good is seen.
  localparam int EXP_LAT = WS + 2;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        data_read = 1'b0, data_write = 1'b0;
  logic [31:0] data_adr_i = '0, data_bus_i = '0;
  logic [3:0]  data_sel_i = '0;
  logic [31:0] data_bus_o;
  logic        data_good, busy, addr_err;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] mm [DEPTH];
  logic [31:0] m_dout;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .nRst(nRst), .data_read(data_read), .data_write(data_write),
    .data_adr_i(data_adr_i), .data_bus_i(data_bus_i), .data_sel_i(data_sel_i),
    .data_bus_o(data_bus_o), .data_good(data_good), .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) mm[i] = '0;
    m_dout = '0;
  endtask

  // Reference: byte address range check, word index, lane merge, sticky read-data register.
  task automatic model_txn(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] exp_rd, output logic exp_err);
    longint unsigned a = longint'(adr);
    longint unsigned lo = longint'(BASE);
    bit inr = (a >= lo) && (a < lo + longint'(DEPTH) * 4);
    int wi = int'((a - lo) / 4);
    exp_err = !inr;
    if (we) begin
      if (inr)
        for (int k = 0; k < 4; k++) if (sel[k]) mm[wi][8*k +: 8] = wd[8*k +: 8];
    end else begin
      m_dout = inr ? mm[wi] : 32'h0;
    end
    exp_rd = m_dout;
  endtask

  task automatic run_txn(input logic we, input logic re, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [3:0] sel,
                         output int lat, output logic [31:0] rd, output logic err);
    @(negedge clk);
    data_write = we; data_read = re; data_adr_i = adr; data_bus_i = wd; data_sel_i = sel;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (data_good === 1'b1) break;
    end
    if (data_good !== 1'b1) lat = -1;
    rd = data_bus_o; err = addr_err;
    data_write = 1'b0; data_read = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [31:0] rd, erd; logic err, eerr;
    nRst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if ({data_good, busy, addr_err} !== 3'b000) begin n_fail++;
      $display("FAIL reset_flags got good/busy/err=%b%b%b want 000", data_good, busy, addr_err); end
    n_cmp++; if (data_bus_o !== 32'h0) begin n_fail++;
      $display("FAIL reset_dout got %h want 0", data_bus_o); end
    nRst = 1'b1;
    model_clear();
    run_txn(1'b0, 1'b1, 32'h10, 32'h0, 4'h0, lat, rd, err);
    model_txn(1'b0, 32'h10, 32'h0, 4'h0, erd, eerr);
    n_cmp++; if (lat !== EXP_LAT) begin n_fail++;
      $display("FAIL reset_read_lat got %0d want %0d", lat, EXP_LAT); end
    n_cmp++; if (rd !== erd) begin n_fail++;
      $display("FAIL reset_read_data got %h want %h", rd, erd); end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd, erd; logic err, eerr;
    run_txn(1'b1, 1'b0, 32'h8, 32'hDEADBEEF, 4'hF, lat, rd, err);
    model_txn(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, erd, eerr);
    n_cmp++; if (lat !== EXP_LAT) begin n_fail++;
      $display("FAIL word_write_lat got %0d want %0d", lat, EXP_LAT); end
    n_cmp++; if (rd !== erd) begin n_fail++;
      $display("FAIL word_write_dout_held got %h want %h", rd, erd); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (data_good !== 1'b0) begin n_fail++;
      $display("FAIL word_good_width got %b want 0", data_good); end
    run_txn(1'b0, 1'b1, 32'h8, 32'h0, 4'h0, lat, rd, err);
    model_txn(1'b0, 32'h8, 32'h0, 4'h0, erd, eerr);
    n_cmp++; if (lat !== EXP_LAT) begin n_fail++;
      $display("FAIL word_read_lat got %0d want %0d", lat, EXP_LAT); end
    n_cmp++; if (rd !== 32'hDEADBEEF || rd !== erd) begin n_fail++;
      $display("FAIL word_read_data got %h want %h", rd, erd); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (data_good !== 1'b0) begin n_fail++;
      $display("FAIL word_read_good_width got %b want 0", data_good); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd, erd; logic err, eerr;
    run_txn(1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF, lat, rd, err);
    model_txn(1'b1, 32'h20, 32'h11223344, 4'hF, erd, eerr);
    run_txn(1'b1, 1'b0, 32'h22, 32'hAABBCCDD, 4'b0101, lat, rd, err);
    model_txn(1'b1, 32'h22, 32'hAABBCCDD, 4'b0101, erd, eerr);
    run_txn(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, lat, rd, err);
    model_txn(1'b0, 32'h20, 32'h0, 4'h0, erd, eerr);
    n_cmp++; if (rd !== 32'h11BB33DD || rd !== erd) begin n_fail++;
      $display("FAIL byte_lane_merge got %h want %h", rd, erd); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd, erd; logic err, eerr;
    run_txn(1'b1, 1'b0, 32'h400, 32'h5, 4'hF, lat, rd, err);
    model_txn(1'b1, 32'h400, 32'h5, 4'hF, erd, eerr);
    n_cmp++; if (lat !== EXP_LAT || err !== eerr) begin n_fail++;
      $display("FAIL oor_write got lat=%0d err=%b want lat=%0d err=%b", lat, err, EXP_LAT, eerr); end
    run_txn(1'b0, 1'b1, 32'h400, 32'h0, 4'h0, lat, rd, err);
    model_txn(1'b0, 32'h400, 32'h0, 4'h0, erd, eerr);
    n_cmp++; if (err !== 1'b1 || rd !== erd) begin n_fail++;
      $display("FAIL oor_read got err=%b data=%h want err=1 data=%h", err, rd, erd); end
    @(posedge clk); @(negedge clk);
    n_cmp++; if (addr_err !== 1'b0) begin n_fail++;
      $display("FAIL oor_err_width got %b want 0", addr_err); end
    run_txn(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, lat, rd, err);
    model_txn(1'b0, 32'h0, 32'h0, 4'h0, erd, eerr);
    n_cmp++; if (rd !== erd || err !== 1'b0) begin n_fail++;
      $display("FAIL oor_word0_intact got %h err=%b want %h err=0", rd, err, erd); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, erd; logic err, eerr;
    run_txn(1'b1, 1'b1, 32'h4, 32'h7, 4'hF, lat, rd, err);
    model_txn(1'b1, 32'h4, 32'h7, 4'hF, erd, eerr);
    n_cmp++; if (lat !== EXP_LAT || rd !== erd) begin n_fail++;
      $display("FAIL collide_write got lat=%0d dout=%h want lat=%0d dout=%h", lat, rd, EXP_LAT, erd); end
    // run_txn dropped both requests at this negedge; re-raise the read within the good cycle.
    data_read = 1'b1; data_adr_i = 32'h4;
    n_cmp++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL b2b_idle_gap got busy=%b want 0", busy); end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (i == 0) begin
        n_cmp++; if (busy !== 1'b1) begin n_fail++;
          $display("FAIL b2b_no_bubble got busy=%b want 1", busy); end
      end
      if (data_good === 1'b1) break;
    end
    if (data_good !== 1'b1) lat = -1;
    data_read = 1'b0;
    model_txn(1'b0, 32'h4, 32'h0, 4'h0, erd, eerr);
    n_cmp++; if (lat !== EXP_LAT || data_bus_o !== erd) begin n_fail++;
      $display("FAIL b2b_read got lat=%0d data=%h want lat=%0d data=%h", lat, data_bus_o, EXP_LAT, erd); end
  endtask

  task automatic test_reset_midop();
    int lat; logic [31:0] rd, erd; logic err, eerr;
    logic seen_good = 1'b0;
    @(negedge clk);
    data_write = 1'b1; data_adr_i = 32'hC; data_bus_i = 32'h99; data_sel_i = 4'hF;
    @(posedge clk); @(negedge clk);
    data_write = 1'b0;
    @(posedge clk); @(negedge clk);
    nRst = 1'b0;
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      if (data_good !== 1'b0) seen_good = 1'b1;
    end
    nRst = 1'b1;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (data_good !== 1'b0) seen_good = 1'b1;
    end
    n_cmp++; if (seen_good !== 1'b0) begin n_fail++;
      $display("FAIL midop_no_good got good seen=%b want 0", seen_good); end
    model_clear();
    run_txn(1'b0, 1'b1, 32'hC, 32'h0, 4'h0, lat, rd, err);
    model_txn(1'b0, 32'hC, 32'h0, 4'h0, erd, eerr);
    n_cmp++; if (rd !== erd) begin n_fail++;
      $display("FAIL midop_write_dropped got %h want %h", rd, erd); end
    run_txn(1'b0, 1'b1, 32'h8, 32'h0, 4'h0, lat, rd, err);
    model_txn(1'b0, 32'h8, 32'h0, 4'h0, erd, eerr);
    n_cmp++; if (rd !== erd) begin n_fail++;
      $display("FAIL midop_array_cleared got %h want %h", rd, erd); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, erd, adr, wd; logic err, eerr, we, re; logic [3:0] sel;
    for (int n = 0; n < 60; n++) begin
      we  = 1'($urandom_range(0, 1));
      re  = we ? 1'($urandom_range(0, 1)) : 1'b1;
      adr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 1100)) : 32'($urandom_range(0, 63));
      wd  = $urandom;
      sel = 4'($urandom_range(0, 15));
      run_txn(we, re, adr, wd, sel, lat, rd, err);
      model_txn(we, adr, wd, sel, erd, eerr);
      n_cmp++; if (lat !== EXP_LAT || rd !== erd || err !== eerr) begin n_fail++;
        $display("FAIL rand[%0d] we=%b adr=%h got lat=%0d data=%h err=%b want lat=%0d data=%h err=%b",
                 n, we, adr, lat, rd, err, EXP_LAT, erd, eerr); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_out_of_range();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
